// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and widths for the round-robin packet-locking mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int unsigned NUM_IN = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage : rr_mux_arbiter_pkg

// File: rtl/rr_mux_arbiter_if.sv
// Source-side and sink-side signals of the 4-input round-robin mux arbiter.
interface rr_mux_arbiter_if
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
);

  logic [N-1:0]      I0;
  logic [N-1:0]      I1;
  logic [N-1:0]      I2;
  logic [N-1:0]      I3;
  logic [NUM_IN-1:0] V;
  logic [NUM_IN-1:0] L;
  logic [NUM_IN-1:0] A;
  logic [SEL_W-1:0]  S;
  logic [N-1:0]      Y;
  logic              Y_valid;
  logic              Y_last;
  logic              Y_ready;

  modport master (
    output I0, I1, I2, I3, V, L, Y_ready,
    input  A, S, Y, Y_valid, Y_last
  );

  modport slave (
    input  I0, I1, I2, I3, V, L, Y_ready,
    output A, S, Y, Y_valid, Y_last
  );

endinterface : rr_mux_arbiter_if

// File: rtl/mod_n_bit_mux.sv
// Plain N-bit 4:1 multiplexer.
module mod_n_bit_mux #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  input  logic [N-1:0] I2,
  input  logic [N-1:0] I3,
  input  logic [1:0]   S,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = I0;
    case (S)
      2'd0:    Y = I0;
      2'd1:    Y = I1;
      2'd2:    Y = I2;
      default: Y = I3;
    endcase
  end

endmodule : mod_n_bit_mux

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbiter with packet lock; selected beat is registered onto Y.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input logic              clk,
  input logic              rst,
  rr_mux_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic [N-1:0]      y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic              y_last_q, y_last_d;

  logic [SEL_W-1:0]  cand;
  logic              found;
  logic [SEL_W-1:0]  sel_c;
  logic              grant;
  logic              load_en;
  logic [NUM_IN-1:0] a_c;
  logic [N-1:0]      mux_y;

  assign load_en = !y_valid_q | bus.Y_ready;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    cand  = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && bus.V[ptr_q + SEL_W'(k)]) begin
        cand  = ptr_q + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    chan_d    = chan_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    sel_c     = ptr_q;
    grant     = 1'b0;
    a_c       = '0;

    case (state_q)
      IDLE: begin
        sel_c = found ? cand : ptr_q;
        grant = load_en & found;
        if (grant) begin
          if (bus.L[cand]) begin
            ptr_d = cand + SEL_W'(1);
          end else begin
            state_d = LOCK;
            chan_d  = cand;
          end
        end
      end
      LOCK: begin
        sel_c = chan_q;
        grant = load_en & bus.V[chan_q];
        if (grant && bus.L[chan_q]) begin
          state_d = IDLE;
          ptr_d   = chan_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty load slot drops Y_valid but keeps the old data visible.
    if (load_en) begin
      y_valid_d = grant;
      if (grant) begin
        y_d      = mux_y;
        y_last_d = bus.L[sel_c];
      end
    end

    if (grant && !rst) begin
      a_c[sel_c] = 1'b1;
    end
  end

  mod_n_bit_mux #(.N(N)) u_mux (
    .I0 (bus.I0),
    .I1 (bus.I1),
    .I2 (bus.I2),
    .I3 (bus.I3),
    .S  (sel_c),
    .Y  (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      chan_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      chan_q    <= chan_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign bus.A       = a_c;
  assign bus.S       = sel_c;
  assign bus.Y       = y_q;
  assign bus.Y_valid = y_valid_q;
  assign bus.Y_last  = y_last_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: reference arbiter model plus directed scenarios.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [N-1:0] d;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] din [4];

  int tests = 0;
  int fails = 0;

  beat_t sb[$];
  bit         m_lock;
  logic [1:0] m_ptr;
  logic [1:0] m_chan;
  bit         m_yv;

  rr_mux_arbiter_if #(.N(N)) bus ();

  rr_mux_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.I0 = din[0];
  assign bus.I1 = din[1];
  assign bus.I2 = din[2];
  assign bus.I3 = din[3];

  always #5 clk = ~clk;

  task automatic set_default_data();
    din[0] = 4'b0101;
    din[1] = 4'b1010;
    din[2] = 4'b0010;
    din[3] = 4'b0110;
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_ptr  = 2'd0;
    m_chan = 2'd0;
    m_yv   = 1'b0;
    sb.delete();
  endtask

  // One clock: drive, check combinational outputs and delivery, advance model, clock.
  task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       output logic [3:0] a_seen);
    int         g;
    bit         load;
    logic [3:0] ea;
    logic [1:0] es;
    beat_t      b;
    bus.V = v;
    bus.L = l;
    bus.Y_ready = rdy;
    #1;
    load = !m_yv || rdy;
    g = -1;
    if (m_lock) begin
      es = m_chan;
      if (v[m_chan]) g = int'(m_chan);
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (int'(m_ptr) + k) % 4;
        if (g < 0 && v[i]) g = i;
      end
      es = (g >= 0) ? 2'(g) : m_ptr;
    end
    if (!load) g = -1;
    ea = (g >= 0) ? 4'(1 << g) : 4'b0000;

    tests++;
    if (bus.A !== ea) begin
      fails++;
      $display("FAIL A: got %b expected %b at %0t", bus.A, ea, $time);
    end
    tests++;
    if (bus.S !== es) begin
      fails++;
      $display("FAIL S: got %0d expected %0d at %0t", bus.S, es, $time);
    end
    tests++;
    if (bus.Y_valid !== m_yv) begin
      fails++;
      $display("FAIL Y_valid: got %b expected %b at %0t", bus.Y_valid, m_yv, $time);
    end
    if (bus.Y_valid === 1'b1 && rdy) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL delivery: unexpected beat Y=%b at %0t", bus.Y, $time);
      end else begin
        b = sb.pop_front();
        if (bus.Y !== b.d || bus.Y_last !== b.last) begin
          fails++;
          $display("FAIL delivery: got Y=%b last=%b expected Y=%b last=%b at %0t",
                   bus.Y, bus.Y_last, b.d, b.last, $time);
        end
      end
    end
    a_seen = bus.A;

    if (load) begin
      m_yv = (g >= 0);
      if (g >= 0) begin
        sb.push_back('{d: din[g], last: l[g]});
        if (l[g]) begin
          m_lock = 1'b0;
          m_ptr  = 2'(g + 1);
        end else if (!m_lock) begin
          m_lock = 1'b1;
          m_chan = 2'(g);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: A got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.V = 4'b1111;
    bus.L = 4'b1111;
    bus.Y_ready = 1'b1;
    #1;
    tests++;
    if (bus.A !== 4'b0000) begin
      fails++;
      $display("FAIL reset_A: got %b expected 0000", bus.A);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.Y !== 4'b0000 || bus.Y_valid !== 1'b0 || bus.Y_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: got Y=%b valid=%b last=%b expected 0000/0/0",
               bus.Y, bus.Y_valid, bus.Y_last);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_rotation();
    logic [3:0] a;
    logic [3:0] exp_a [5];
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1, a);
      check_a("rotation", a, exp_a[i]);
      if (i < 4) begin
        tests++;
        if (bus.Y !== din[i]) begin
          fails++;
          $display("FAIL rotation_Y: got %b expected %b", bus.Y, din[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a;
    test_reset();
    cycle(4'b1111, 4'b1111, 1'b1, a);
    check_a("bp_first", a, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 4'b1111, 1'b0, a);
      check_a("bp_stall", a, 4'b0000);
      tests++;
      if (bus.Y !== 4'b0101 || bus.Y_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold: got Y=%b valid=%b expected 0101/1", bus.Y, bus.Y_valid);
      end
    end
    cycle(4'b1111, 4'b1111, 1'b1, a);
    check_a("bp_resume", a, 4'b0010);
  endtask

  task automatic test_packet_lock();
    logic [3:0] a;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0011, (i == 3) ? 4'b0001 : 4'b0000, 1'b1, a);
      check_a("lock_beat", a, 4'b0001);
      tests++;
      if (bus.Y !== 4'b0101 || bus.Y_last !== (i == 3)) begin
        fails++;
        $display("FAIL lock_Y: beat %0d got Y=%b last=%b expected 0101/%0d",
                 i, bus.Y, bus.Y_last, (i == 3));
      end
    end
    cycle(4'b0011, 4'b1111, 1'b1, a);
    check_a("lock_next", a, 4'b0010);
  endtask

  task automatic test_wrap();
    logic [3:0] a;
    test_reset();
    cycle(4'b0100, 4'b1111, 1'b1, a);
    check_a("wrap_ch2", a, 4'b0100);
    cycle(4'b1001, 4'b1111, 1'b1, a);
    check_a("wrap_ch3", a, 4'b1000);
    cycle(4'b1001, 4'b1111, 1'b1, a);
    check_a("wrap_ch0", a, 4'b0001);
  endtask

  task automatic test_reset_mid_lock();
    logic [3:0] a;
    test_reset();
    cycle(4'b0100, 4'b0000, 1'b1, a);
    check_a("midlock_grant", a, 4'b0100);
    cycle(4'b0100, 4'b0000, 1'b1, a);
    check_a("midlock_hold", a, 4'b0100);
    test_reset();
    cycle(4'b0010, 4'b1111, 1'b1, a);
    check_a("midlock_after", a, 4'b0010);
    tests++;
    if (bus.Y !== 4'b1010 || bus.Y_valid !== 1'b1) begin
      fails++;
      $display("FAIL midlock_Y: got Y=%b valid=%b expected 1010/1", bus.Y, bus.Y_valid);
    end
  endtask

  task automatic test_drain();
    logic [3:0] a;
    test_reset();
    cycle(4'b0001, 4'b1111, 1'b1, a);
    check_a("drain_load", a, 4'b0001);
    cycle(4'b0000, 4'b1111, 1'b1, a);
    check_a("drain_idle", a, 4'b0000);
    tests++;
    if (bus.Y_valid !== 1'b0 || bus.Y !== 4'b0101 || bus.S !== 2'd1) begin
      fails++;
      $display("FAIL drain: got valid=%b Y=%b S=%0d expected 0/0101/1",
               bus.Y_valid, bus.Y, bus.S);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) din[k] = 4'($urandom_range(0, 15));
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), a);
      tests++;
      if (!(a == 4'b0000 || $onehot(a))) begin
        fails++;
        $display("FAIL onehot: A=%b", a);
      end
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 1'b1, a);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d beats undelivered, expected 0", sb.size());
    end
    set_default_data();
  endtask

  initial begin
    set_default_data();
    bus.V = 4'b0000;
    bus.L = 4'b0000;
    bus.Y_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_backpressure();
    test_packet_lock();
    test_wrap();
    test_reset_mid_lock();
    test_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
